// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard sitting between ID and EX: tracks in-flight destination registers,
// selects forwarding sources, and raises bubble/flush/hold/interrupt-accept controls.
module hazard_scoreboard #(
    parameter int NUM_SRC  = 3,
    parameter int NUM_HOLD = 3,
    parameter int DEPTH    = 2,
    parameter int REG_W    = 4,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_irq_flag,
    input  logic                       i_pc_en,
    input  logic                       i_issue_vld,
    input  logic                       i_issue_rd_vld,
    input  logic [REG_W-1:0]           i_issue_rd_code,
    input  logic                       i_issue_is_load,
    input  logic [NUM_SRC*REG_W-1:0]   i_src_code,
    input  logic [NUM_SRC-1:0]         i_src_vld,
    input  logic [NUM_HOLD-1:0]        i_hold,
    output logic                       o_id_flush,
    output logic                       o_ex_flush,
    output logic                       o_bubble,
    output logic                       o_pipelinehold,
    output logic [NUM_SRC*SEL_W-1:0]   o_fwd_sel,
    output logic                       o_irq_take,
    output logic                       o_irq_pend
);

    localparam logic [REG_W-1:0] PC_CODE = '1;

    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0]            r_load;
    logic [DEPTH-1:0][REG_W-1:0] r_code;
    logic                        r_irq_pend;

    logic                        w_hold;
    logic                        w_pc_hazard;
    logic                        w_entry0_vld;
    logic [NUM_SRC-1:0]          w_load_use;
    logic [REG_W-1:0]            w_src;

    // Scan oldest to youngest so the youngest match overwrites; PC code never forwards.
    always_comb begin
        o_fwd_sel  = '0;
        w_load_use = '0;
        w_src      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_src = i_src_code[k*REG_W +: REG_W];
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (i_src_vld[k] && (w_src != PC_CODE) && r_vld[j] && (r_code[j] == w_src)) begin
                    if ((j == 0) && r_load[0]) begin
                        w_load_use[k]                = 1'b1;
                        o_fwd_sel[k*SEL_W +: SEL_W] = '0;
                    end else begin
                        w_load_use[k]                = 1'b0;
                        o_fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(j + 1);
                    end
                end
            end
        end
    end

    assign w_hold         = |i_hold;
    assign w_pc_hazard    = i_pc_en | (r_vld[0] & (r_code[0] == PC_CODE));
    assign o_pipelinehold = w_hold;
    assign o_bubble       = (|w_load_use) & ~w_hold;
    assign o_id_flush     = w_pc_hazard;
    assign o_irq_take     = r_irq_pend & ~w_hold & ~o_bubble & ~w_pc_hazard;
    assign o_ex_flush     = w_pc_hazard | o_bubble | o_irq_take | w_hold;
    assign o_irq_pend     = r_irq_pend;

    // A squashed or stalled ID instruction enters EX as a NOP, so its write is dropped.
    assign w_entry0_vld = i_issue_vld & i_issue_rd_vld & ~o_ex_flush & ~o_id_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld      <= '0;
            r_load     <= '0;
            r_code     <= '0;
            r_irq_pend <= 1'b0;
        end else begin
            r_irq_pend <= i_irq_flag | (r_irq_pend & ~o_irq_take);
            if (!w_hold) begin
                for (int j = 1; j < DEPTH; j++) begin
                    r_vld[j]  <= r_vld[j-1];
                    r_load[j] <= r_load[j-1];
                    r_code[j] <= r_code[j-1];
                end
                r_vld[0]  <= w_entry0_vld;
                r_load[0] <= i_issue_is_load;
                r_code[0] <= i_issue_rd_code;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the in-flight instructions.
module tb_hazard_scoreboard;

    localparam int NUM_SRC  = 3;
    localparam int NUM_HOLD = 3;
    localparam int DEPTH    = 2;
    localparam int REG_W    = 4;
    localparam int SEL_W    = 2;

    logic clk = 1'b0;
    logic rst;
    logic irqFlag, pcEn, issueVld, issueRdVld, issueIsLoad;
    logic [REG_W-1:0]         issueRdCode;
    logic [NUM_SRC*REG_W-1:0] srcCode;
    logic [NUM_SRC-1:0]       srcVld;
    logic [NUM_HOLD-1:0]      hold;
    logic idFlush, exFlush, bubble, pipeHold, irqTake, irqPend;
    logic [NUM_SRC*SEL_W-1:0] fwdSel;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       vld;
        logic [3:0] code;
        logic       load;
    } entry_t;

    entry_t inFlight[$];
    logic   mPend;
    logic   expIdFlush, expExFlush, expBubble, expHold, expTake;
    logic [NUM_SRC*SEL_W-1:0] expFwd;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_SRC(NUM_SRC), .NUM_HOLD(NUM_HOLD), .DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_irq_flag(irqFlag), .i_pc_en(pcEn),
        .i_issue_vld(issueVld), .i_issue_rd_vld(issueRdVld), .i_issue_rd_code(issueRdCode),
        .i_issue_is_load(issueIsLoad), .i_src_code(srcCode), .i_src_vld(srcVld), .i_hold(hold),
        .o_id_flush(idFlush), .o_ex_flush(exFlush), .o_bubble(bubble), .o_pipelinehold(pipeHold),
        .o_fwd_sel(fwdSel), .o_irq_take(irqTake), .o_irq_pend(irqPend)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        inFlight.delete();
        for (int j = 0; j < DEPTH; j++) inFlight.push_back('0);
        mPend = 1'b0;
    endtask

    // Youngest-first search of the in-flight list decides each source's data origin.
    task automatic modelEvaluate();
        logic loadUse, found, pcHaz;
        loadUse = 1'b0;
        expFwd  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            found = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (!found && srcVld[k] && srcCode[k*REG_W +: REG_W] != 4'hF &&
                    inFlight[j].vld && inFlight[j].code == srcCode[k*REG_W +: REG_W]) begin
                    found = 1'b1;
                    if (j == 0 && inFlight[0].load) loadUse = 1'b1;
                    else expFwd[k*SEL_W +: SEL_W] = 2'(j + 1);
                end
            end
        end
        expHold    = |hold;
        pcHaz      = pcEn | (inFlight[0].vld && inFlight[0].code == 4'hF);
        expIdFlush = pcHaz;
        expBubble  = loadUse & ~expHold;
        expTake    = mPend & ~expHold & ~expBubble & ~pcHaz;
        expExFlush = pcHaz | expBubble | expTake | expHold;
    endtask

    task automatic modelAdvance();
        entry_t e;
        if (!expHold) begin
            e.vld  = issueVld & issueRdVld & ~expExFlush & ~expIdFlush;
            e.code = issueRdCode;
            e.load = issueIsLoad;
            inFlight.push_front(e);
            void'(inFlight.pop_back());
        end
        mPend = irqFlag | (mPend & ~expTake);
    endtask

    task automatic applyStimulus(input logic irq, input logic pc, input logic iv, input logic rv,
                                 input logic [3:0] rd, input logic ld, input logic [11:0] sc,
                                 input logic [2:0] sv, input logic [2:0] hd);
        @(negedge clk);
        irqFlag = irq; pcEn = pc; issueVld = iv; issueRdVld = rv; issueRdCode = rd;
        issueIsLoad = ld; srcCode = sc; srcVld = sv; hold = hd;
        #1;
        modelEvaluate();
        checkOutput("id_flush", idFlush, expIdFlush);
        checkOutput("ex_flush", exFlush, expExFlush);
        checkOutput("bubble", bubble, expBubble);
        checkOutput("pipelinehold", pipeHold, expHold);
        checkOutput("fwd_sel", fwdSel, expFwd);
        checkOutput("irq_take", irqTake, expTake);
        checkOutput("irq_pend", irqPend, mPend);
        modelAdvance();
    endtask

    task automatic applyReset();
        @(negedge clk);
        irqFlag = 0; pcEn = 0; issueVld = 0; issueRdVld = 0; issueRdCode = 0;
        issueIsLoad = 0; srcCode = 0; srcVld = 0; hold = 0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_outputs", {idFlush, exFlush, bubble, pipeHold, fwdSel, irqTake, irqPend}, '0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] pickCode();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    initial begin
        rst = 1'b1;
        irqFlag = 0; pcEn = 0; issueVld = 0; issueRdVld = 0; issueRdCode = 0;
        issueIsLoad = 0; srcCode = 0; srcVld = 0; hold = 0;
        modelReset();
        #12;
        checkOutput("reset_state", {idFlush, exFlush, bubble, pipeHold, fwdSel, irqTake, irqPend}, '0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] ALU forwarding from entry 0 then entry 1");
        applyStimulus(0, 0, 1, 1, 4'd3, 0, 12'h000, 3'b000, 3'b000);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 12'h003, 3'b001, 3'b000);
        checkOutput("tp_alu_fwd1", fwdSel[1:0], 2'd1);
        checkOutput("tp_alu_nobubble", bubble, 1'b0);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 12'h003, 3'b001, 3'b000);
        checkOutput("tp_alu_fwd2", fwdSel[1:0], 2'd2);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 12'h003, 3'b001, 3'b000);
        checkOutput("tp_alu_fwd0", fwdSel[1:0], 2'd0);

        $display("[TB] load-use stall");
        applyStimulus(0, 0, 1, 1, 4'd5, 1, 12'h000, 3'b000, 3'b000);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 12'h050, 3'b010, 3'b000);
        checkOutput("tp_lu_bubble", bubble, 1'b1);
        checkOutput("tp_lu_exflush", exFlush, 1'b1);
        checkOutput("tp_lu_fwd0", fwdSel[3:2], 2'd0);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 12'h050, 3'b010, 3'b000);
        checkOutput("tp_lu_release", bubble, 1'b0);
        checkOutput("tp_lu_fwd2", fwdSel[3:2], 2'd2);

        $display("[TB] youngest match wins");
        applyStimulus(0, 0, 1, 1, 4'd2, 0, 12'h000, 3'b000, 3'b000);
        applyStimulus(0, 0, 1, 1, 4'd2, 0, 12'h000, 3'b000, 3'b000);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 12'h200, 3'b100, 3'b000);
        checkOutput("tp_youngest", fwdSel[5:4], 2'd1);

        $display("[TB] hold with interrupt arriving");
        applyStimulus(0, 0, 1, 1, 4'd7, 0, 12'h000, 3'b000, 3'b000);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(c == 1, 0, 1, 1, 4'd9, 0, 12'h007, 3'b001, 3'b010);
            checkOutput("tp_hold", pipeHold, 1'b1);
            checkOutput("tp_hold_exflush", exFlush, 1'b1);
            checkOutput("tp_hold_fwd", fwdSel[1:0], 2'd1);
            checkOutput("tp_hold_take", irqTake, 1'b0);
        end
        checkOutput("tp_hold_pend", irqPend, 1'b1);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 12'h007, 3'b001, 3'b000);
        checkOutput("tp_release_fwd", fwdSel[1:0], 2'd1);
        checkOutput("tp_irq_take", irqTake, 1'b1);
        checkOutput("tp_irq_exflush", exFlush, 1'b1);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 12'h000, 3'b000, 3'b000);
        checkOutput("tp_irq_cleared", irqPend, 1'b0);

        $display("[TB] PC write via r15 blocks interrupt");
        applyStimulus(1, 0, 1, 1, 4'hF, 0, 12'h000, 3'b000, 3'b000);
        applyStimulus(0, 0, 1, 1, 4'd4, 0, 12'h000, 3'b000, 3'b000);
        checkOutput("tp_r15_idflush", idFlush, 1'b1);
        checkOutput("tp_r15_exflush", exFlush, 1'b1);
        checkOutput("tp_r15_notake", irqTake, 1'b0);
        applyStimulus(0, 0, 1, 1, 4'd6, 0, 12'h000, 3'b000, 3'b000);
        applyReset();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                              $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, pickCode(),
                              $urandom_range(0, 9) < 4, {pickCode(), pickCode(), pickCode()},
                              3'($urandom_range(0, 7)),
                              ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
